code_lock_fsm: RTL and testbench

CODE_LOCK_FSM -- requirements
Module: code_lock_fsm

---
 rtl/code_lock_pkg.sv | 15 +
 rtl/lock_timer.sv | 28 ++
 rtl/code_lock_fsm.sv | 134 +++++++++++++
 tb/tb_code_lock_fsm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// Shared types and sizing helpers for the keypad code lock.
package code_lock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_UNLOCKED,
        ST_NEW_CODE,
        ST_LOCKOUT
    } lock_state_t;

    function automatic int fail_cnt_w(input int max_tries);
        return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Lockout countdown: done is high in the last cycle of a LOCKOUT_CYC-long window
// that opens on the edge sampling start.
module lock_timer #(
    parameter int LOCKOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int TMR_W = (LOCKOUT_CYC < 1) ? 1 : $clog2(LOCKOUT_CYC + 1);

    logic [TMR_W-1:0] remain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remain <= '0;
        end else if (start) begin
            remain <= TMR_W'(LOCKOUT_CYC);
        end else if (remain != '0) begin
            remain <= remain - TMR_W'(1);
        end
    end

    assign done = (remain == TMR_W'(1));

endmodule

// File: rtl/code_lock_fsm.sv
// Keypad code lock: digit entry, retry lockout and in-field code change.
module code_lock_fsm
    import code_lock_pkg::*;
#(
    parameter int DIGIT_W     = 4,
    parameter int CODE_LEN    = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 1000,
    parameter logic [CODE_LEN*DIGIT_W-1:0] INIT_CODE = 16'h1234
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DIGIT_W-1:0]                  digit,
    input  logic                                digit_valid,
    input  logic                                enter,
    input  logic                                change_req,
    input  logic                                lock_cmd,
    output logic                                unlocked,
    output logic                                buzzer,
    output logic                                err,
    output logic [fail_cnt_w(MAX_TRIES)-1:0]    fail_count
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int FAIL_W = fail_cnt_w(MAX_TRIES);
    localparam int CNT_W  = $clog2(CODE_LEN + 2);

    lock_state_t       state;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] entry_buf;
    logic [CNT_W-1:0]  dig_cnt;
    logic [FAIL_W-1:0] fail_next;
    logic              match;
    logic              start_lockout;
    logic              lockout_done;

    // A digit counter parked at CODE_LEN+1 marks an over-long entry as a mismatch.
    assign match         = (dig_cnt == CNT_W'(CODE_LEN)) && (entry_buf == code);
    assign fail_next     = fail_count + FAIL_W'(1);
    assign start_lockout = (state == ST_LOCKED) && enter && !match &&
                           (fail_next == FAIL_W'(MAX_TRIES));

    lock_timer #(
        .LOCKOUT_CYC(LOCKOUT_CYC)
    ) u_lock_timer (
        .clk  (clk),
        .reset(reset),
        .start(start_lockout),
        .done (lockout_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LOCKED;
            code       <= INIT_CODE;
            entry_buf  <= '0;
            dig_cnt    <= '0;
            fail_count <= '0;
            unlocked   <= 1'b0;
            buzzer     <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_LOCKED: begin
                    if (enter) begin
                        entry_buf <= '0;
                        dig_cnt   <= '0;
                        if (match) begin
                            state      <= ST_UNLOCKED;
                            unlocked   <= 1'b1;
                            fail_count <= '0;
                        end else begin
                            err        <= 1'b1;
                            fail_count <= fail_next;
                            if (start_lockout) begin
                                state  <= ST_LOCKOUT;
                                buzzer <= 1'b1;
                            end
                        end
                    end else if (digit_valid) begin
                        entry_buf <= (entry_buf << DIGIT_W) | CODE_W'(digit);
                        if (dig_cnt != CNT_W'(CODE_LEN + 1))
                            dig_cnt <= dig_cnt + CNT_W'(1);
                    end
                end
                ST_UNLOCKED: begin
                    if (lock_cmd) begin
                        state     <= ST_LOCKED;
                        unlocked  <= 1'b0;
                        entry_buf <= '0;
                        dig_cnt   <= '0;
                    end else if (change_req) begin
                        state     <= ST_NEW_CODE;
                        entry_buf <= '0;
                        dig_cnt   <= '0;
                    end
                end
                ST_NEW_CODE: begin
                    if (lock_cmd) begin
                        state     <= ST_LOCKED;
                        unlocked  <= 1'b0;
                        err       <= 1'b1;
                        entry_buf <= '0;
                        dig_cnt   <= '0;
                    end else if (enter) begin
                        state     <= ST_UNLOCKED;
                        entry_buf <= '0;
                        dig_cnt   <= '0;
                        if (dig_cnt == CNT_W'(CODE_LEN))
                            code <= entry_buf;
                        else
                            err <= 1'b1;
                    end else if (digit_valid) begin
                        entry_buf <= (entry_buf << DIGIT_W) | CODE_W'(digit);
                        if (dig_cnt != CNT_W'(CODE_LEN + 1))
                            dig_cnt <= dig_cnt + CNT_W'(1);
                    end
                end
                ST_LOCKOUT: begin
                    if (lockout_done) begin
                        state      <= ST_LOCKED;
                        buzzer     <= 1'b0;
                        fail_count <= '0;
                        entry_buf  <= '0;
                        dig_cnt    <= '0;
                    end
                end
                default: state <= ST_LOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_code_lock_fsm.sv
// Directed bench for code_lock_fsm with default parameters (code 1234, 3 tries, 1000-cycle lockout).
module tb_code_lock_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit;
    logic       digit_valid;
    logic       enter;
    logic       change_req;
    logic       lock_cmd;
    logic       unlocked;
    logic       buzzer;
    logic       err;
    logic [1:0] fail_count;

    int checks = 0;
    int errors = 0;

    code_lock_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .digit      (digit),
        .digit_valid(digit_valid),
        .enter      (enter),
        .change_req (change_req),
        .lock_cmd   (lock_cmd),
        .unlocked   (unlocked),
        .buzzer     (buzzer),
        .err        (err),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic key(input logic [3:0] d);
        @(negedge clk);
        digit       = d;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    task automatic key4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic submit();
        @(negedge clk);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic do_lock();
        @(negedge clk);
        lock_cmd = 1'b1;
        @(negedge clk);
        lock_cmd = 1'b0;
    endtask

    task automatic do_change();
        @(negedge clk);
        change_req = 1'b1;
        @(negedge clk);
        change_req = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({tag, "_unlocked"}, unlocked, 0);
        chk({tag, "_buzzer"}, buzzer, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_fail"}, fail_count, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; digit = '0; digit_valid = 0; enter = 0; change_req = 0; lock_cmd = 0;
        #1;
        chk("rst_unlocked", unlocked, 0);
        chk("rst_buzzer", buzzer, 0);
        chk("rst_err", err, 0);
        chk("rst_fail", fail_count, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Correct code unlocks one cycle after enter
        key4(1, 2, 3, 4);
        chk("pre_enter_unlocked", unlocked, 0);
        submit();
        chk("ok_unlocked", unlocked, 1);
        chk("ok_err", err, 0);
        chk("ok_fail", fail_count, 0);
        do_lock();
        chk("relock", unlocked, 0);

        // Too few and too many digits
        key(1); key(2); key(3);
        submit();
        chk("short_err", err, 1);
        chk("short_fail", fail_count, 1);
        chk("short_unlocked", unlocked, 0);
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        key4(1, 2, 3, 4); key(4);
        submit();
        chk("long_err", err, 1);
        chk("long_fail", fail_count, 2);
        key4(1, 2, 3, 4);
        submit();
        chk("recover_unlocked", unlocked, 1);
        chk("recover_fail", fail_count, 0);
        do_lock();

        // Three wrong submits -> lockout for exactly 1000 cycles
        key4(1, 2, 3, 5); submit();
        chk("bad1_err", err, 1);
        chk("bad1_fail", fail_count, 1);
        chk("bad1_buzzer", buzzer, 0);
        key4(1, 2, 3, 5); submit();
        chk("bad2_err", err, 1);
        chk("bad2_fail", fail_count, 2);
        key4(1, 2, 3, 5); submit();
        chk("bad3_err", err, 1);
        chk("bad3_fail", fail_count, 3);
        chk("bad3_buzzer", buzzer, 1);
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            case (i)
                10: begin digit = 1; digit_valid = 1; end
                11: digit = 2;
                12: digit = 3;
                13: digit = 4;
                14: begin digit_valid = 0; enter = 1; end
                15: enter = 0;
                20: change_req = 1;
                21: change_req = 0;
                500: begin
                    chk("lo_mid_buzzer", buzzer, 1);
                    chk("lo_mid_unlocked", unlocked, 0);
                    chk("lo_mid_fail", fail_count, 3);
                end
                999: chk("lo_999_buzzer", buzzer, 1);
                1000: begin
                    chk("lo_end_buzzer", buzzer, 0);
                    chk("lo_end_fail", fail_count, 0);
                end
                default: ;
            endcase
        end
        // Keys typed during lockout must not have been buffered
        submit();
        chk("post_lo_err", err, 1);
        chk("post_lo_unlocked", unlocked, 0);
        chk("post_lo_fail", fail_count, 1);
        key4(1, 2, 3, 4); submit();
        chk("post_lo_open", unlocked, 1);
        chk("post_lo_clear", fail_count, 0);

        // Change code to 9876
        do_change();
        chk("nc_unlocked", unlocked, 1);
        key4(9, 8, 7, 6); submit();
        chk("nc_commit_unlocked", unlocked, 1);
        chk("nc_commit_err", err, 0);
        do_lock();
        chk("nc_locked", unlocked, 0);
        key4(1, 2, 3, 4); submit();
        chk("old_code_rej", err, 1);
        chk("old_code_unlocked", unlocked, 0);
        key4(9, 8, 7, 6); submit();
        chk("new_code_ok", unlocked, 1);
        chk("new_code_fail", fail_count, 0);

        // Short new code is rejected and the code is kept
        do_change();
        key(9); key(8); submit();
        chk("nc_short_err", err, 1);
        chk("nc_short_unlocked", unlocked, 1);
        // lock_cmd aborts a change in progress
        do_change();
        key4(1, 1, 1, 1);
        do_lock();
        chk("nc_abort_err", err, 1);
        chk("nc_abort_unlocked", unlocked, 0);
        key4(9, 8, 7, 6); submit();
        chk("kept_code_ok", unlocked, 1);

        // Reset mid NEW_CODE restores INIT_CODE
        do_change();
        key(5);
        pulse_reset("rst_nc");
        key4(9, 8, 7, 6); submit();
        chk("rst_nc_old_rej", err, 1);
        key4(1, 2, 3, 4); submit();
        chk("rst_nc_init_ok", unlocked, 1);
        do_lock();

        // Reset during LOCKOUT
        for (int k = 0; k < 3; k++) begin
            key4(0, 0, 0, 0); submit();
        end
        chk("lo2_buzzer", buzzer, 1);
        pulse_reset("rst_lo");
        key4(1, 2, 3, 4); submit();
        chk("rst_lo_open", unlocked, 1);
        do_lock();

        // Enter with digit_valid: the digit is discarded
        key(1); key(2); key(3);
        @(negedge clk);
        digit = 4; digit_valid = 1; enter = 1;
        @(negedge clk);
        digit_valid = 0; enter = 0;
        chk("same_cyc_short_err", err, 1);
        chk("same_cyc_short_unl", unlocked, 0);
        key4(1, 2, 3, 4);
        @(negedge clk);
        digit = 9; digit_valid = 1; enter = 1;
        @(negedge clk);
        digit_valid = 0; enter = 0;
        chk("same_cyc_open", unlocked, 1);
        chk("same_cyc_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
